arcade_input_mapper: RTL

Parametrised player-input front end for arcade cores, between `hps_io` (PS/2 key events, joysticks) and the core's active-low input registers. It holds keyboard key state and merges it with the joysticks. It applies one of four screen orientations to the directions. A coin sequencer generates fixed-width, rate-limited coin pulses from coin keys, coin buttons or, optionally, start presses. It also provides a wrapping coin counter. Outputs are active-high and registered; the top level inverts and packs them into `in0_reg`/`in1_reg`.

---
 rtl/arcade_input_mapper.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key state, joystick merge, screen rotation, coin pulse sequencer.
// Latency: joystick->outputs 1 clk_sys edge, PS/2 event->outputs 2 edges, coin edge->coin pulse 2 edges.
// Backpressure: none; inputs sampled every clock, surplus coin requests beyond one pending are dropped.
module arcade_input_mapper #(
   parameter int          PLAYERS    = 2,
   parameter logic [23:0] COIN_PULSE = 24'd2400000,
   parameter logic [23:0] COIN_GAP   = 24'd1200000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic [1:0]  rotate,
   input  logic        auto_coin,
   output logic [3:0]  p1_dir,
   output logic [3:0]  p2_dir,
   output logic        p1_fire,
   output logic        p2_fire,
   output logic        start1,
   output logic        start2,
   output logic        cheat,
   output logic        coin,
   output logic [7:0]  coin_count
);

   // A single player cabinet folds player-2 controls onto player 1
   localparam bit SOLO = (PLAYERS == 1);

   typedef struct packed {
      logic p1_u;
      logic p1_d;
      logic p1_l;
      logic p1_r;
      logic p1_fire_sp;
      logic p1_fire_ctl;
      logic p2_u;
      logic p2_d;
      logic p2_l;
      logic p2_r;
      logic p2_fire;
      logic start1;
      logic start2;
      logic cheat;
      logic coin;
   } key_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_GAP
   } coin_state_t;

   key_state_t  keys;
   logic        old_toggle;
   logic        armed;

   logic [3:0]  p1_phys;
   logic [3:0]  p2_phys;
   logic        p1_fire_c;
   logic        p2_fire_c;
   logic        start1_src;
   logic        start2_src;
   logic        req;
   logic        req_q;
   logic        req_prev;
   logic        trigger;

   coin_state_t state;
   logic [23:0] cnt;
   logic        pending;

   // Joystick bits [15:8] carry nothing this block uses
   logic        unused_joy_bits;
   assign unused_joy_bits = ^{joystick_0[15:8], joystick_1[15:8]};

   // Joystick layout {U,D,L,R} at [3:0] repacked to output order {D,R,L,U}
   function automatic logic [3:0] joy_dir(input logic [15:0] joy);
      return {joy[2], joy[0], joy[1], joy[3]};
   endfunction

   // Map physical {D,R,L,U} to logical {D,R,L,U} for the screen orientation
   function automatic logic [3:0] orient(input logic [1:0] rot, input logic [3:0] d);
      logic [3:0] res;
      case (rot)
         2'd0:    res = d;
         2'd1:    res = {d[2], d[0], d[3], d[1]};
         2'd2:    res = {d[1], d[3], d[0], d[2]};
         default: res = {d[0], d[1], d[2], d[3]};
      endcase
      return res;
   endfunction

   // PS/2 event decode: first clock after reset only latches the toggle level
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         keys       <= '0;
         old_toggle <= 1'b0;
         armed      <= 1'b0;
      end else if (!armed) begin
         old_toggle <= ps2_key[10];
         armed      <= 1'b1;
      end else if (ps2_key[10] != old_toggle) begin
         old_toggle <= ps2_key[10];
         case (ps2_key[8:0])
            9'h175:  keys.p1_u        <= ps2_key[9];
            9'h172:  keys.p1_d        <= ps2_key[9];
            9'h16B:  keys.p1_l        <= ps2_key[9];
            9'h174:  keys.p1_r        <= ps2_key[9];
            9'h029:  keys.p1_fire_sp  <= ps2_key[9];
            9'h014:  keys.p1_fire_ctl <= ps2_key[9];
            9'h02D:  keys.p2_u        <= ps2_key[9];
            9'h02B:  keys.p2_d        <= ps2_key[9];
            9'h023:  keys.p2_l        <= ps2_key[9];
            9'h034:  keys.p2_r        <= ps2_key[9];
            9'h01C:  keys.p2_fire     <= ps2_key[9];
            9'h005:  keys.start1      <= ps2_key[9];
            9'h006:  keys.start2      <= ps2_key[9];
            9'h003:  keys.cheat       <= ps2_key[9];
            9'h02E:  keys.coin        <= ps2_key[9];
            default: ;
         endcase
      end
   end

   // Merge keyboard and joysticks into physical controls and the coin request
   always_comb begin
      p1_phys    = {keys.p1_d, keys.p1_r, keys.p1_l, keys.p1_u} | joy_dir(joystick_0);
      p2_phys    = {keys.p2_d, keys.p2_r, keys.p2_l, keys.p2_u} | joy_dir(joystick_1);
      p1_fire_c  = keys.p1_fire_sp | keys.p1_fire_ctl | joystick_0[4];
      p2_fire_c  = keys.p2_fire | joystick_1[4];
      if (SOLO) begin
         p1_phys   = p1_phys | p2_phys;
         p1_fire_c = p1_fire_c | p2_fire_c;
      end
      start1_src = keys.start1 | joystick_0[5] | joystick_1[5];
      start2_src = keys.start2 | joystick_0[6] | joystick_1[6];
      req        = keys.coin | joystick_0[7] | joystick_1[7] |
                   (auto_coin & (start1_src | start2_src));
   end

   // Registered active-high player outputs, rotation applied at this stage
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         p1_dir  <= 4'b0;
         p2_dir  <= 4'b0;
         p1_fire <= 1'b0;
         p2_fire <= 1'b0;
         start1  <= 1'b0;
         start2  <= 1'b0;
         cheat   <= 1'b0;
      end else begin
         p1_dir  <= orient(rotate, p1_phys);
         p2_dir  <= SOLO ? 4'b0 : orient(rotate, p2_phys);
         p1_fire <= p1_fire_c;
         p2_fire <= SOLO ? 1'b0 : p2_fire_c;
         start1  <= start1_src;
         start2  <= start2_src;
         cheat   <= keys.cheat;
      end
   end

   // Register the coin request and keep its previous value for edge detection
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= 1'b0;
         req_prev <= 1'b0;
      end else begin
         req_q    <= req;
         req_prev <= req_q;
      end
   end

   assign trigger = req_q & ~req_prev;

   // Coin sequencer: fixed-width pulse, enforced gap, one-deep request queue
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= 24'd0;
         pending    <= 1'b0;
         coin       <= 1'b0;
         coin_count <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state      <= ST_PULSE;
                  cnt        <= COIN_PULSE - 24'd1;
                  coin       <= 1'b1;
                  coin_count <= coin_count + 8'd1;
               end
            end
            ST_PULSE: begin
               if (trigger) pending <= 1'b1;
               if (cnt == 24'd0) begin
                  state <= ST_GAP;
                  cnt   <= COIN_GAP - 24'd1;
                  coin  <= 1'b0;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            ST_GAP: begin
               if (cnt == 24'd0) begin
                  // A trigger landing on expiry is served like a pending one
                  if (pending || trigger) begin
                     state      <= ST_PULSE;
                     cnt        <= COIN_PULSE - 24'd1;
                     coin       <= 1'b1;
                     coin_count <= coin_count + 8'd1;
                     pending    <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 24'd1;
                  if (trigger) pending <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               coin  <= 1'b0;
            end
         endcase
      end
   end

endmodule
